// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states, offer lock and
// the streak counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_I    = 2'd1,
        LOCK_D    = 2'd2
    } arb_lock_t;

    // Bits needed to hold 0..limit inclusive.
    function automatic int streak_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// Combinational winner select: a pending lock wins, otherwise D has
// priority unless I has waited through STARVE_LIMIT consecutive D grants.
module arb_prio_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = streak_w(STARVE_LIMIT)
) (
    input  logic          d_valid,
    input  logic          i_valid,
    input  arb_lock_t     lock,
    input  logic [SW-1:0] streak,
    output logic          sel_d
);

    always_comb begin
        sel_d = 1'b0;
        unique case (lock)
            LOCK_D:  sel_d = 1'b1;
            LOCK_I:  sel_d = 1'b0;
            default: sel_d = d_valid && !(i_valid && (streak == SW'(STARVE_LIMIT)));
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported memory between fetch (I) and load/store (D):
// one outstanding transaction, response routed back to its owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [AWIDTH-1:0]   i_addr,
    output logic                i_rsp_valid,
    output logic [DWIDTH-1:0]   i_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [AWIDTH-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DWIDTH-1:0]   d_wdata,
    input  logic [DWIDTH/8-1:0] d_wstrb,
    output logic                d_rsp_valid,
    output logic [DWIDTH-1:0]   d_rdata,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [AWIDTH-1:0]   m_addr,
    output logic                m_we,
    output logic [DWIDTH-1:0]   m_wdata,
    output logic [DWIDTH/8-1:0] m_wstrb,
    input  logic                m_rsp_valid,
    input  logic [DWIDTH-1:0]   m_rdata
);

    localparam int SW = streak_w(STARVE_LIMIT);

    arb_state_t    state, state_nxt;
    arb_lock_t     lock, lock_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          sel_d;
    logic          accept;

    arb_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_prio_sel (
        .d_valid (d_req_valid),
        .i_valid (i_req_valid),
        .lock    (lock),
        .streak  (streak),
        .sel_d   (sel_d)
    );

    // Read data is only qualified by the matching rsp_valid.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign m_wdata = d_wdata;

    always_comb begin
        state_nxt   = state;
        lock_nxt    = lock;
        streak_nxt  = streak;
        m_req_valid = 1'b0;
        m_addr      = i_addr;
        m_we        = 1'b0;
        m_wstrb     = '0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        accept      = 1'b0;
        // Everything stays quiet while reset is held.
        if (!rst) begin
            unique case (state)
                ARB_IDLE: begin
                    m_req_valid = i_req_valid | d_req_valid;
                    accept      = m_req_valid && m_req_ready;
                    if (sel_d) begin
                        m_addr      = d_addr;
                        m_we        = d_we;
                        m_wstrb     = d_wstrb;
                        d_req_ready = m_req_valid && m_req_ready;
                    end else begin
                        i_req_ready = m_req_valid && m_req_ready;
                    end
                    if (accept) begin
                        state_nxt = sel_d ? ARB_WAIT_D : ARB_WAIT_I;
                        lock_nxt  = LOCK_NONE;
                        if (sel_d && i_req_valid)
                            streak_nxt = (streak == SW'(STARVE_LIMIT)) ? streak : streak + SW'(1);
                        else
                            streak_nxt = '0;
                    end else if (m_req_valid) begin
                        // Hold the offer on the same requester until memory takes it.
                        lock_nxt = sel_d ? LOCK_D : LOCK_I;
                    end
                end
                ARB_WAIT_I: begin
                    i_rsp_valid = m_rsp_valid;
                    if (m_rsp_valid) state_nxt = ARB_IDLE;
                end
                ARB_WAIT_D: begin
                    d_rsp_valid = m_rsp_valid;
                    if (m_rsp_valid) state_nxt = ARB_IDLE;
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            lock   <= LOCK_NONE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            lock   <= lock_nxt;
            streak <= streak_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, i_req_ready, i_rsp_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_wstrb;
    logic          m_req_valid, m_req_ready, m_we, m_rsp_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
        .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held valid; memory answers one cycle after each accept.
    // seq bit k is 1 when the k-th accept went to D.
    task automatic grant_seq(input int n, output logic [15:0] seq);
        seq = '0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_we        = 1'b0;
        m_req_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            int w;
            logic is_d;
            w = 0;
            #1;
            while (!(m_req_valid && m_req_ready) && w < 8) begin
                tick();
                w++;
            end
            chk("seq_accept", m_req_valid && m_req_ready, 1'b1);
            is_d = d_req_ready;
            seq[k] = is_d;
            tick();
            m_rsp_valid = 1'b1;
            m_rdata     = 32'(k);
            #1;
            chk("seq_rsp_own", is_d ? d_rsp_valid : i_rsp_valid, 1'b1);
            chk("seq_rsp_oth", is_d ? i_rsp_valid : d_rsp_valid, 1'b0);
            tick();
            m_rsp_valid = 1'b0;
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    // Reference model state for the randomized run.
    logic [31:0] mem [16];
    bit          busy, i_out, d_out, exp_we, pend_act;
    bit          exp_mrv, win_d, acc, rsp;
    int          owner, offer, streak_m, pend_cnt;
    logic [31:0] pend_data, exp_data;
    logic [3:0]  ridx, midx;
    logic [15:0] seq;

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b1; i_addr = 32'h40;
        d_req_valid = 1'b1; d_addr = 32'h80; d_we = 1'b1; d_wdata = '0; d_wstrb = 4'hf;
        m_req_ready = 1'b1; m_rsp_valid = 1'b1; m_rdata = '0;
        tick();
        tick();
        chk("rst_mrv", m_req_valid, 1'b0);
        chk("rst_irdy", i_req_ready, 1'b0);
        chk("rst_drdy", d_req_ready, 1'b0);
        chk("rst_mwe", m_we, 1'b0);
        chk("rst_wstrb", m_wstrb, 4'h0);
        chk("rst_irsp", i_rsp_valid, 1'b0);
        chk("rst_drsp", d_rsp_valid, 1'b0);
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 1'b0; d_wstrb = '0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Fetch only
        i_req_valid = 1'b1; i_addr = 32'h100; m_req_ready = 1'b1;
        #1;
        chk("t1_addr", m_addr, 32'h100);
        chk("t1_we", m_we, 1'b0);
        chk("t1_irdy", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("t1_wait_irsp", i_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b1; m_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_irsp", i_rsp_valid, 1'b1);
        chk("t1_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_drsp", d_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b0;

        // Simultaneous fetch and load: D first, I one cycle after D's response
        i_req_valid = 1'b1; i_addr = 32'h200;
        d_req_valid = 1'b1; d_addr = 32'h1000; d_we = 1'b0;
        #1;
        chk("t2_daddr", m_addr, 32'h1000);
        chk("t2_drdy", d_req_ready, 1'b1);
        chk("t2_irdy", i_req_ready, 1'b0);
        tick();
        d_req_valid = 1'b0;
        #1;
        chk("t2_wait_mrv", m_req_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b1; m_rdata = 32'h11112222;
        #1;
        chk("t2_drsp", d_rsp_valid, 1'b1);
        chk("t2_drdata", d_rdata, 32'h11112222);
        chk("t2_irsp", i_rsp_valid, 1'b0);
        chk("t2_bubble", m_req_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b0;
        #1;
        chk("t2_iaddr", m_addr, 32'h200);
        chk("t2_igrant", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        m_rsp_valid = 1'b1; m_rdata = 32'h33334444;
        #1;
        chk("t2_irsp2", i_rsp_valid, 1'b1);
        tick();
        m_rsp_valid = 1'b0;

        // Store
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h1004;
        d_wdata = 32'h0000ABCD; d_wstrb = 4'b0011;
        #1;
        chk("t3_we", m_we, 1'b1);
        chk("t3_wstrb", m_wstrb, 4'b0011);
        chk("t3_wdata", m_wdata, 32'h0000ABCD);
        chk("t3_addr", m_addr, 32'h1004);
        tick();
        d_req_valid = 1'b0; d_we = 1'b0; d_wstrb = '0;
        m_rsp_valid = 1'b1;
        #1;
        chk("t3_drsp", d_rsp_valid, 1'b1);
        chk("t3_irsp", i_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b0;

        // Starvation guard: D,D,D,D,I,D,D,D,D,I
        grant_seq(10, seq);
        chk("t4_order", seq, 16'h01EF);

        // Backpressure lock on an I offer
        m_req_ready = 1'b0;
        i_req_valid = 1'b1; i_addr = 32'h300;
        d_addr = 32'h2000; d_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) d_req_valid = 1'b1;
            if (c == 3) m_req_ready = 1'b1;
            #1;
            chk("t5_addr", m_addr, 32'h300);
            chk("t5_drdy", d_req_ready, 1'b0);
            chk("t5_irdy", i_req_ready, c == 3);
            tick();
        end
        i_req_valid = 1'b0;
        m_rsp_valid = 1'b1;
        #1;
        chk("t5_irsp", i_rsp_valid, 1'b1);
        tick();
        m_rsp_valid = 1'b0;
        #1;
        chk("t5_dgrant", d_req_ready, 1'b1);
        chk("t5_daddr", m_addr, 32'h2000);
        tick();
        d_req_valid = 1'b0;
        m_rsp_valid = 1'b1;
        #1;
        chk("t5_drsp", d_rsp_valid, 1'b1);
        tick();
        m_rsp_valid = 1'b0;

        // Reset while in WAIT_D with a nonzero streak
        grant_seq(3, seq);
        chk("t6_pre", seq, 16'h0007);
        i_req_valid = 1'b1; d_req_valid = 1'b1; d_addr = 32'h3000;
        #1;
        chk("t6_dwin", d_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_mrv", m_req_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        m_rsp_valid = 1'b1;
        #1;
        chk("t6_no_drsp", d_rsp_valid, 1'b0);
        chk("t6_no_irsp", i_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 1'b0;
        grant_seq(5, seq);
        chk("t6_streak0", seq, 16'h000F);

        // Randomized run against the transaction-level model
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        busy = 0; i_out = 0; d_out = 0; pend_act = 0; exp_we = 0;
        owner = 0; offer = 0; streak_m = 0; pend_cnt = 0;
        pend_data = '0; exp_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_req_valid && !i_out && $urandom_range(3) == 0) begin
                i_req_valid = 1'b1;
                i_addr = 32'($urandom_range(15)) << 2;
            end
            if (!d_req_valid && !d_out && $urandom_range(2) == 0) begin
                d_req_valid = 1'b1;
                d_addr  = 32'($urandom_range(15)) << 2;
                d_we    = 1'($urandom_range(1));
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(15));
            end
            m_req_ready = ($urandom_range(2) != 0);
            if (pend_act) begin
                m_rsp_valid = (pend_cnt == 0);
                m_rdata     = pend_data;
            end else begin
                m_rsp_valid = ($urandom_range(7) == 0);
                m_rdata     = $urandom;
            end
            #1;
            exp_mrv = !busy && (i_req_valid || d_req_valid);
            if (offer != 0) win_d = (offer == 2);
            else win_d = d_req_valid && !(i_req_valid && streak_m >= STARVE);
            acc = exp_mrv && m_req_ready;
            rsp = busy && m_rsp_valid;
            chk("r_mrv", m_req_valid, exp_mrv);
            chk("r_irdy", i_req_ready, acc && !win_d);
            chk("r_drdy", d_req_ready, acc && win_d);
            chk("r_irsp", i_rsp_valid, rsp && owner == 1);
            chk("r_drsp", d_rsp_valid, rsp && owner == 2);
            if (rsp && !exp_we) chk("r_rdata", (owner == 1) ? i_rdata : d_rdata, exp_data);
            if (exp_mrv) begin
                chk("r_addr", m_addr, win_d ? d_addr : i_addr);
                chk("r_we", m_we, win_d && d_we);
                chk("r_wstrb", m_wstrb, win_d ? d_wstrb : 4'h0);
                if (win_d && d_we) chk("r_wdata", m_wdata, d_wdata);
            end
            if (rsp) begin
                busy = 0; pend_act = 0;
                if (owner == 1) i_out = 0; else d_out = 0;
            end else if (pend_act) begin
                pend_cnt--;
            end
            if (acc) begin
                busy = 1; owner = win_d ? 2 : 1; offer = 0;
                pend_act = 1; pend_cnt = $urandom_range(2);
                ridx = win_d ? d_addr[5:2] : i_addr[5:2];
                midx = m_addr[5:2];
                exp_we = win_d && d_we;
                exp_data = mem[ridx];
                pend_data = mem[midx];
                if (exp_we)
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) mem[midx][8*b +: 8] = m_wdata[8*b +: 8];
                if (win_d && i_req_valid) streak_m = (streak_m >= STARVE) ? STARVE : streak_m + 1;
                else streak_m = 0;
            end else if (exp_mrv) begin
                offer = win_d ? 2 : 1;
            end
            tick();
            if (acc) begin
                if (win_d) begin d_req_valid = 1'b0; d_out = 1; end
                else begin i_req_valid = 1'b0; i_out = 1; end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Arbitrates between the two, locks each offer until the memory accepts it, tracks the one outstanding transaction and routes its response back to the owner.
- Sits between the fetch/LSU logic of riscv_core and the memory model.
- Data has priority over fetch, with a starvation guard that periodically grants fetch.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive D grants made while I was waiting; after this many, I wins the next arbitration. Must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted.
- i_addr  in  AWIDTH  fetch address.
- i_rsp_valid  out  1  fetch read data valid (1-cycle pulse).
- i_rdata  out  DWIDTH  fetch read data.
- d_req_valid  in  1  load/store request.
- d_req_ready  out  1  load/store accepted.
- d_addr  in  AWIDTH  load/store address.
- d_we  in  1  1=store, 0=load.
- d_wdata  in  DWIDTH  store data.
- d_wstrb  in  DWIDTH/8  store byte enables.
- d_rsp_valid  out  1  load data / store ack (1-cycle pulse).
- d_rdata  out  DWIDTH  load data.
- m_req_valid  out  1  request to memory.
- m_req_ready  in  1  memory accepts request.
- m_addr  out  AWIDTH  memory address.
- m_we  out  1  memory write enable.
- m_wdata  out  DWIDTH  memory write data.
- m_wstrb  out  DWIDTH/8  memory byte enables.
- m_rsp_valid  in  1  memory response (reads and write acks).
- m_rdata  in  DWIDTH  memory read data.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- State machine: IDLE, WAIT_I, WAIT_D. Reset values:
  - state=IDLE, lock=NONE, streak=0.
  - All *_valid and *_ready outputs are 0 while rst=1.
  - m_we and m_wstrb are 0 while rst=1; other data outputs are don't-care.
- Requester protocol: valid/ready handshake. Once valid is high, the requester holds valid and its payload stable until ready. Each requester has at most one request outstanding.
- IDLE:
  - m_req_valid = i_req_valid | d_req_valid.
  - The winner drives m_addr/m_we/m_wdata/m_wstrb combinationally. For I: m_we=0, m_wstrb=0.
  - Winner selection:
    - If lock≠NONE, the locked requester wins.
    - Otherwise, if d_req_valid and !(i_req_valid && streak==STARVE_LIMIT), D wins.
    - Otherwise I wins.
  - If m_req_valid && !m_req_ready: lock is set to the winner, so the offer is never switched mid-handshake.
  - If m_req_ready: winner's *_req_ready = m_req_ready (combinational, same cycle). The other requester's ready is 0.
  - Accept (m_req_valid && m_req_ready): next state is WAIT_D or WAIT_I, and lock is cleared to NONE.
- Streak counter, updated on accept:
  - D accepted with i_req_valid=1: streak <= streak+1, saturating at STARVE_LIMIT.
  - D accepted with i_req_valid=0: streak <= 0.
  - I accepted: streak <= 0.
- WAIT_x:
  - m_req_valid=0 and both req_ready=0.
  - On m_rsp_valid: x_rsp_valid=1 and x_rdata=m_rdata in the same cycle (combinational); next state is IDLE.
  - The other requester's rsp_valid stays 0.
  - A new request can be accepted no earlier than the cycle after the response, so there is one bubble per transaction.
- Latency: accept to response equals memory latency (0 added cycles). Response to next accept is ≥1 cycle.
- m_rsp_valid in IDLE (spurious, or left over from a transaction cut off by reset) is ignored; no rsp_valid is produced.
- Reset mid-transaction: state returns to IDLE the next cycle. The outstanding response is dropped, and lock and streak are cleared.
- i_rdata/d_rdata may be driven from m_rdata unconditionally. They are only meaningful when the matching rsp_valid is 1.

Decomposition:
- Shared package/header mem_arb_defs.vh, containing:
  - State encodings: ARB_IDLE=2'd0, ARB_WAIT_I=2'd1, ARB_WAIT_D=2'd2.
  - Lock encodings: LOCK_NONE, LOCK_I, LOCK_D.
- One sub-module, arb_prio_sel: a combinational winner select taking d_valid, i_valid, lock, streak and STARVE_LIMIT.
- The FSM, lock and streak registers live in the top module.

Test Plan:
1. Fetch only: i_req_valid=1, i_addr=0x100, m_req_ready=1; memory responds 2 cycles later with 0xDEADBEEF.
   - Expect in the accept cycle: m_addr=0x100, m_we=0, i_req_ready=1.
   - Expect at the response: i_rsp_valid=1, i_rdata=0xDEADBEEF, d_rsp_valid=0.
2. Simultaneous requests: fetch at 0x200 and load (d_we=0) at 0x1000 in the same cycle.
   - Expect D granted first (m_addr=0x1000), then d_rsp_valid.
   - Expect I granted exactly 1 cycle after D's response, with m_addr=0x200.
3. Store: d_we=1, d_addr=0x1004, d_wdata=0x0000ABCD, d_wstrb=4'b0011.
   - Expect m_we=1, m_wstrb=0011, m_wdata=0x0000ABCD.
   - Expect d_rsp_valid=1 on the memory ack; i_rsp_valid stays 0.
4. Starvation, STARVE_LIMIT=4: d_req_valid and i_req_valid held high continuously.
   - Expect accept order D,D,D,D,I,D,D,D,D,I.
5. Backpressure lock: I offers 0x300 with m_req_ready=0 for 3 cycles; D raises its request in cycle 2; then m_req_ready=1.
   - Expect m_addr=0x300 in all 4 cycles and I accepted first.
   - Expect d_req_ready=0 throughout.
6. Reset mid-transaction: rst=1 for 1 cycle while in WAIT_D; m_rsp_valid=1 arrives 2 cycles later.
   - Expect no d_rsp_valid or i_rsp_valid.
   - Expect a new fetch accepted normally, with streak reset to 0.
